// File: rtl/sd_spi_cmd_engine_if.sv
// Command/response and low-level SPI byte signals of the SD SPI command engine.
// master = controller/shifter side, slave = engine side.
interface sd_spi_cmd_engine_if;
    logic        i_cmd_stb;
    logic [2:0]  i_cmd_type;
    logic [5:0]  i_cmd;
    logic [31:0] i_cmd_data;
    logic        o_busy;
    logic        o_ll_stb;
    logic [7:0]  o_ll_byte;
    logic        i_ll_busy;
    logic        i_ll_stb;
    logic [7:0]  i_ll_byte;
    logic        o_cmd_sent;
    logic        o_rxvalid;
    logic [39:0] o_response;
    logic        o_timeout;

    modport master (
        output i_cmd_stb, i_cmd_type, i_cmd, i_cmd_data, i_ll_busy, i_ll_stb, i_ll_byte,
        input  o_busy, o_ll_stb, o_ll_byte, o_cmd_sent, o_rxvalid, o_response, o_timeout
    );

    modport slave (
        input  i_cmd_stb, i_cmd_type, i_cmd, i_cmd_data, i_ll_busy, i_ll_stb, i_ll_byte,
        output o_busy, o_ll_stb, o_ll_byte, o_cmd_sent, o_rxvalid, o_response, o_timeout
    );
endinterface

// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI command engine: sends a 48-bit command with CRC7, collects
// R1/R1b/R2/R3/R7 responses, waits out R1b busy, with NCR and busy timeouts.
module sd_spi_cmd_engine #(
    parameter int unsigned NCR_MAX = 8,
    parameter int unsigned LGBUSY  = 16,
    parameter int unsigned OPT_R2  = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    sd_spi_cmd_engine_if.slave bus
);
    localparam int unsigned CRC_STEPS = 20;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_NCR, S_RESP, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {T_R1, T_R1B, T_R2, T_R3} rtype_t;

    state_t            state;
    rtype_t            rtype;
    logic [31:0]       tx_sr;
    logic [2:0]        byte_idx;
    logic [6:0]        crc;
    logic [39:0]       crc_sr;
    logic [4:0]        crc_cnt;
    logic [7:0]        ncr_cnt;
    logic [2:0]        resp_cnt;
    logic [LGBUSY-1:0] busy_cnt;

    logic ll_accept, rx_ok, crc_done, start;

    assign ll_accept = bus.o_ll_stb && !bus.i_ll_busy;
    assign rx_ok     = bus.o_cmd_sent && bus.i_ll_stb;
    assign crc_done  = (crc_cnt == 5'(CRC_STEPS));
    assign start     = bus.i_cmd_stb && (state == S_IDLE || state == S_DONE);

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic rtype_t decode_type(input logic [2:0] t);
        case (t)
            3'b001:  return T_R1B;
            3'b010:  return (OPT_R2 != 0) ? T_R2 : T_R1;
            3'b011:  return T_R3;
            default: return T_R1;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= S_IDLE;
            rtype          <= T_R1;
            tx_sr          <= '0;
            byte_idx       <= '0;
            crc            <= '0;
            crc_sr         <= '0;
            crc_cnt        <= 5'(CRC_STEPS);
            ncr_cnt        <= '0;
            resp_cnt       <= '0;
            busy_cnt       <= '0;
            bus.o_busy     <= 1'b0;
            bus.o_ll_stb   <= 1'b0;
            bus.o_ll_byte  <= 8'hFF;
            bus.o_cmd_sent <= 1'b0;
            bus.o_rxvalid  <= 1'b0;
            bus.o_response <= '1;
            bus.o_timeout  <= 1'b0;
        end else begin
            // CRC7 runs two bits per cycle in the background from command accept
            if (!crc_done) begin
                crc     <= crc7_step(crc7_step(crc, crc_sr[39]), crc_sr[38]);
                crc_sr  <= {crc_sr[37:0], 2'b00};
                crc_cnt <= crc_cnt + 5'd1;
            end

            case (state)
                S_CMD: begin
                    if (ll_accept) begin
                        byte_idx <= byte_idx + 3'd1;
                        if (byte_idx == 3'd5) begin
                            bus.o_cmd_sent <= 1'b1;
                            bus.o_ll_byte  <= 8'hFF;
                            ncr_cnt        <= '0;
                            state          <= S_NCR;
                        end else if (byte_idx == 3'd4) begin
                            if (crc_done) bus.o_ll_byte <= {crc, 1'b1};
                            else          bus.o_ll_stb  <= 1'b0;
                        end else begin
                            bus.o_ll_byte <= tx_sr[31:24];
                            tx_sr         <= {tx_sr[23:0], 8'h00};
                        end
                    end else if (!bus.o_ll_stb && crc_done) begin
                        bus.o_ll_byte <= {crc, 1'b1};
                        bus.o_ll_stb  <= 1'b1;
                    end
                end
                S_NCR: begin
                    if (rx_ok) begin
                        if (!bus.i_ll_byte[7]) begin
                            bus.o_response[39:32] <= bus.i_ll_byte;
                            case (rtype)
                                T_R2:  begin resp_cnt <= 3'd1; state <= S_RESP; end
                                T_R3:  begin resp_cnt <= 3'd4; state <= S_RESP; end
                                T_R1B: state <= S_BUSY;
                                default: begin
                                    state <= S_DONE; bus.o_ll_stb <= 1'b0;
                                    bus.o_busy <= 1'b0; bus.o_rxvalid <= 1'b1;
                                end
                            endcase
                        end else if (ncr_cnt == 8'(NCR_MAX - 1)) begin
                            bus.o_timeout <= 1'b1;
                            state <= S_DONE; bus.o_ll_stb <= 1'b0;
                            bus.o_busy <= 1'b0; bus.o_rxvalid <= 1'b1;
                        end else begin
                            ncr_cnt <= ncr_cnt + 8'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (rx_ok) begin
                        bus.o_response[31:0] <= {bus.o_response[23:0], bus.i_ll_byte};
                        resp_cnt <= resp_cnt - 3'd1;
                        if (resp_cnt == 3'd1) begin
                            state <= S_DONE; bus.o_ll_stb <= 1'b0;
                            bus.o_busy <= 1'b0; bus.o_rxvalid <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (rx_ok) begin
                        if (bus.i_ll_byte != 8'h00) begin
                            state <= S_DONE; bus.o_ll_stb <= 1'b0;
                            bus.o_busy <= 1'b0; bus.o_rxvalid <= 1'b1;
                        end else if (busy_cnt == ~LGBUSY'(1)) begin
                            bus.o_timeout <= 1'b1;
                            state <= S_DONE; bus.o_ll_stb <= 1'b0;
                            bus.o_busy <= 1'b0; bus.o_rxvalid <= 1'b1;
                        end else begin
                            busy_cnt <= busy_cnt + LGBUSY'(1);
                        end
                    end
                end
                S_DONE: begin
                    state          <= S_IDLE;
                    bus.o_rxvalid  <= 1'b0;
                    bus.o_cmd_sent <= 1'b0;
                end
                default: ;
            endcase

            // A new command is taken from IDLE or DONE and overrides the above
            if (start) begin
                state          <= S_CMD;
                rtype          <= decode_type(bus.i_cmd_type);
                tx_sr          <= bus.i_cmd_data;
                byte_idx       <= '0;
                crc            <= '0;
                crc_sr         <= {2'b01, bus.i_cmd, bus.i_cmd_data};
                crc_cnt        <= '0;
                ncr_cnt        <= '0;
                busy_cnt       <= '0;
                bus.o_busy     <= 1'b1;
                bus.o_ll_stb   <= 1'b1;
                bus.o_ll_byte  <= {2'b01, bus.i_cmd};
                bus.o_cmd_sent <= 1'b0;
                bus.o_rxvalid  <= 1'b0;
                bus.o_response <= '1;
                bus.o_timeout  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed testbench for sd_spi_cmd_engine: known SD command CRCs, response
// types, NCR/busy timeouts and their boundaries, shifter stalls and mid-command reset.
module tb_sd_spi_cmd_engine;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sd_spi_cmd_engine_if bus();

    sd_spi_cmd_engine #(.NCR_MAX(8), .LGBUSY(4), .OPT_R2(1)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},     64'(bus.o_busy),     64'd0);
        check({tag, "_ll_stb"},   64'(bus.o_ll_stb),   64'd0);
        check({tag, "_ll_byte"},  64'(bus.o_ll_byte),  64'hFF);
        check({tag, "_cmd_sent"}, 64'(bus.o_cmd_sent), 64'd0);
        check({tag, "_rxvalid"},  64'(bus.o_rxvalid),  64'd0);
        check({tag, "_response"}, 64'(bus.o_response), 64'hFF_FFFF_FFFF);
        check({tag, "_timeout"},  64'(bus.o_timeout),  64'd0);
    endtask

    // Issue one command from a negedge; returns at the negedge of the DONE cycle
    task automatic do_cmd(input string name, input logic [2:0] typ, input logic [5:0] idx,
                          input logic [31:0] arg, input logic [47:0] tx,
                          input int rx_n, input logic [127:0] rx,
                          input logic [39:0] exp_resp, input logic exp_to,
                          input bit stall, input bit glitch, input bit partial);
        logic [47:0] got;
        int n, c, early;
        bus.i_cmd_stb  = 1'b1;
        bus.i_cmd_type = typ;
        bus.i_cmd      = idx;
        bus.i_cmd_data = arg;
        @(negedge clk);
        bus.i_cmd_stb = 1'b0;
        check({name, "_acc_busy"},    64'(bus.o_busy),     64'd1);
        check({name, "_acc_rxvalid"}, 64'(bus.o_rxvalid),  64'd0);
        check({name, "_acc_resp"},    64'(bus.o_response), 64'hFF_FFFF_FFFF);
        check({name, "_acc_timeout"}, 64'(bus.o_timeout),  64'd0);

        got = '0; n = 0; c = 0;
        while (n < 6 && c < 200) begin
            bus.i_cmd_stb = glitch && (c == 2);
            if (glitch && c == 2) begin
                bus.i_cmd_type = 3'b011;
                bus.i_cmd      = 6'h3F;
                bus.i_cmd_data = 32'hFFFF_FFFF;
            end
            bus.i_ll_busy = stall ? ((c < 30) ? 1'b1 : c[0]) : 1'b0;
            if (stall && c == 29)
                check({name, "_stall_hold"}, 64'({bus.o_ll_stb, bus.o_ll_byte}), 64'({1'b1, tx[47:40]}));
            if (bus.o_ll_stb && !bus.i_ll_busy) begin
                got = {got[39:0], bus.o_ll_byte};
                n++;
            end
            c++;
            @(negedge clk);
        end
        bus.i_cmd_stb = 1'b0;
        bus.i_ll_busy = 1'b0;
        check({name, "_tx_count"}, 64'(n), 64'd6);
        check({name, "_tx_bytes"}, 64'(got), 64'(tx));
        check({name, "_cmd_sent"}, 64'({bus.o_cmd_sent, bus.o_ll_stb, bus.o_ll_byte}), 64'h3FF);

        early = 0;
        for (int i = 0; i < rx_n; i++) begin
            bus.i_ll_stb  = 1'b1;
            bus.i_ll_byte = rx[127 - 8*i -: 8];
            @(negedge clk);
            if (i < rx_n - 1 && bus.o_rxvalid) early++;
        end
        bus.i_ll_stb  = 1'b0;
        bus.i_ll_byte = 8'hFF;
        if (!partial) begin
            check({name, "_no_early_done"}, 64'(early), 64'd0);
            check({name, "_rxvalid"},  64'(bus.o_rxvalid),  64'd1);
            check({name, "_done_idle"}, 64'({bus.o_busy, bus.o_ll_stb}), 64'd0);
            check({name, "_response"}, 64'(bus.o_response), 64'(exp_resp));
            check({name, "_timeout"},  64'(bus.o_timeout),  64'(exp_to));
            check({name, "_sent_held"}, 64'(bus.o_cmd_sent), 64'd1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.i_cmd_stb  = 1'b0;
        bus.i_cmd_type = 3'b000;
        bus.i_cmd      = 6'd0;
        bus.i_cmd_data = 32'd0;
        bus.i_ll_busy  = 1'b0;
        bus.i_ll_stb   = 1'b0;
        bus.i_ll_byte  = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // CMD0, with a strobe while busy that must be ignored
        do_cmd("cmd0", 3'b000, 6'd0, 32'h0, 48'h40_0000_0000_95,
               3, {24'hFFFF01, 104'h0}, 40'h01_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        // CMD8 / R7 behind a stalled shifter, accepted straight from DONE
        do_cmd("cmd8", 3'b011, 6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87,
               6, {48'hFF01_0000_01AA, 80'h0}, 40'h01_0000_01AA, 1'b0, 1'b1, 1'b0, 1'b0);
        // CMD55 with an undefined type code, decoded as R1
        do_cmd("cmd55", 3'b110, 6'd55, 32'h0, 48'h77_0000_0000_65,
               1, {8'h00, 120'h0}, 40'h00_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("cmd41", 3'b001, 6'd41, 32'h4000_0000, 48'h69_4000_0000_77,
               4, {32'h0000_00FF, 96'h0}, 40'h00_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("idle_after_done", 64'({bus.o_rxvalid, bus.o_cmd_sent, bus.o_busy}), 64'd0);

        // NCR timeout after the 8th filler byte; timeout stays set while idle
        do_cmd("ncr_to", 3'b000, 6'd0, 32'h0, 48'h40_0000_0000_95,
               8, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 40'hFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("timeout_sticky", 64'(bus.o_timeout), 64'd1);
        do_cmd("ncr_edge", 3'b000, 6'd0, 32'h0, 48'h40_0000_0000_95,
               8, {64'hFFFF_FFFF_FFFF_FF01, 64'h0}, 40'h01_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("r2", 3'b010, 6'd0, 32'h0, 48'h40_0000_0000_95,
               3, {24'hFF00AB, 104'h0}, 40'h00_FFFF_FFAB, 1'b0, 1'b0, 1'b0, 1'b0);

        // Busy wait with a 4-bit counter: 14 zeros survive, the 15th times out
        do_cmd("busy_edge", 3'b001, 6'd41, 32'h4000_0000, 48'h69_4000_0000_77,
               16, {120'h0, 8'hFF}, 40'h00_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("busy_to", 3'b001, 6'd41, 32'h4000_0000, 48'h69_4000_0000_77,
               16, 128'h0, 40'h00_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an R7 response
        repeat (2) @(negedge clk);
        do_cmd("abort", 3'b011, 6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87,
               3, {24'hFF0100, 104'h0}, 40'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("no_req_after_reset", 64'({bus.o_ll_stb, bus.o_busy}), 64'd0);
        do_cmd("cmd0_again", 3'b000, 6'd0, 32'h0, 48'h40_0000_0000_95,
               2, {16'hFF01, 112'h0}, 40'h01_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("final_idle", 64'({bus.o_rxvalid, bus.o_cmd_sent, bus.o_busy}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
